// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked unsigned ALU with an iterative multiply/divide datapath.
// Optional feature macro: ALU_MULDIV_EN enables MUL, DIV and MOD (shift/subtract datapath).
// Without it those opcodes report an invalid opcode in a single cycle.
// Accepted operands are latched in IDLE and evaluated one cycle later in EXEC.
// EXEC either finishes directly or hands off to CALC for the iterative ops.

module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       error_flag,
    output logic             busy
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

    localparam logic [3:0] OpNot = 4'h0;
    localparam logic [3:0] OpShl = 4'h1;
    localparam logic [3:0] OpMul = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpShr = 4'h5;
    localparam logic [3:0] OpDiv = 4'h6;
    localparam logic [3:0] OpAnd = 4'h7;
    localparam logic [3:0] OpOr  = 4'h8;
    localparam logic [3:0] OpCmp = 4'h9;
    localparam logic [3:0] OpMod = 4'hA;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {StIdle, StExec, StCalc, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
`endif

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH-1:0] sc_result;
    logic [1:0]       sc_flag;
    logic             sc_iter;
    logic [WIDTH:0]   sum_ext;

`ifdef ALU_MULDIV_EN
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [CntW-1:0]  cnt_q;
    // acc_hi: product high half (MUL) or partial remainder (DIV/MOD)
    // acc_lo: multiplier shift register (MUL) or dividend/quotient shift register (DIV/MOD)
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;

    // One radix-2 step: shift-add for MUL, restoring subtract for DIV/MOD
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q == OpMul) begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else begin
            // Remainder always stays below b, so the low WIDTH bits are exact
            acc_hi_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end
    end
`endif

    // Single-cycle result and flag, plus the decision to iterate
    always_comb begin
        sc_result = '0;
        sc_flag   = 2'b00;
        sc_iter   = 1'b0;
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        case (op_q)
            OpNot: sc_result = ~a_q;
            OpShl: if (b_q < WidthVal) sc_result = a_q << b_q[ShW-1:0];
            OpShr: if (b_q < WidthVal) sc_result = a_q >> b_q[ShW-1:0];
            OpAdd: begin
                sc_result = sum_ext[WIDTH-1:0];
                if (sum_ext[WIDTH]) sc_flag = 2'b11;
            end
            OpSub: begin
                sc_result = a_q - b_q;
                if (a_q < b_q) sc_flag = 2'b11;
            end
            OpAnd: sc_result = a_q & b_q;
            OpOr:  sc_result = a_q | b_q;
            OpCmp: begin
                if (a_q == b_q)     sc_result = '0;
                else if (a_q < b_q) sc_result = WIDTH'(1);
                else                sc_result = WIDTH'(2);
            end
`ifdef ALU_MULDIV_EN
            OpMul: if (b_q != '0) sc_iter = 1'b1;
            OpDiv, OpMod: begin
                if (b_q == '0) sc_flag = 2'b01;
                else           sc_iter = 1'b1;
            end
`endif
            default: sc_flag = 2'b10;
        endcase
    end

    // Control FSM with registered handshake, status and result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            error_flag <= 2'b00;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
`ifdef ALU_MULDIV_EN
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q     <= operation;
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        in_ready <= 1'b0;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    if (sc_iter) begin
`ifdef ALU_MULDIV_EN
                        state_q  <= StCalc;
                        busy     <= 1'b1;
                        cnt_q    <= CntW'(WIDTH);
                        acc_hi_q <= '0;
                        acc_lo_q <= (op_q == OpMul) ? b_q : a_q;
`endif
                    end else begin
                        result     <= sc_result;
                        error_flag <= sc_flag;
                        out_valid  <= 1'b1;
                        state_q    <= StDone;
                    end
                end
`ifdef ALU_MULDIV_EN
                StCalc: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q - CntW'(1);
                    // Last of WIDTH steps: take the step outputs straight into the result
                    if (cnt_q == CntW'(1)) begin
                        result     <= (op_q == OpMod) ? acc_hi_d : acc_lo_d;
                        error_flag <= (op_q == OpMul && acc_hi_d != '0) ? 2'b11 : 2'b00;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        state_q    <= StDone;
                    end
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
// Iterative-op expectations follow whether ALU_MULDIV_EN is defined for the build.

module tb_alu_multicycle;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  operation = 4'h0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [1:0]  error_flag;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .error_flag (error_flag),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Issue one op, return result/flag and cycles from accept edge to out_valid, then consume
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [1:0] flg, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        operation = op; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; operation = 4'h3; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        res = result; flg = error_flag;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({in_ready, out_valid, busy, error_flag, result} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b flg=%b res=%h, expected 1 0 0 00 0",
                     in_ready, out_valid, busy, error_flag, result);
        end
    endtask

    task automatic test_add();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'h3, 32'd10, 32'd5, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd15}) begin
            tests_failed++; $display("FAIL add_basic: got %b/%h expected 00/0000000f", f, r);
        end
        tests_run++;
        if (l !== 1) begin
            tests_failed++; $display("FAIL add_latency: got %0d expected 1", l);
        end
        run_op(4'h3, 32'hFFFF_FFFF, 32'd1, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b11, 32'd0}) begin
            tests_failed++; $display("FAIL add_carry: got %b/%h expected 11/00000000", f, r);
        end
    endtask

    task automatic test_sub_cmp();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'h4, 32'd20, 32'd8, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd12}) begin
            tests_failed++; $display("FAIL sub_basic: got %b/%h expected 00/0000000c", f, r);
        end
        run_op(4'h4, 32'd3, 32'd5, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b11, 32'hFFFF_FFFE}) begin
            tests_failed++; $display("FAIL sub_borrow: got %b/%h expected 11/fffffffe", f, r);
        end
        run_op(4'h9, 32'd10, 32'd20, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd1}) begin
            tests_failed++; $display("FAIL cmp_less: got %b/%h expected 00/00000001", f, r);
        end
        run_op(4'h9, 32'd7, 32'd7, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd0}) begin
            tests_failed++; $display("FAIL cmp_equal: got %b/%h expected 00/00000000", f, r);
        end
        run_op(4'h9, 32'd20, 32'd10, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd2}) begin
            tests_failed++; $display("FAIL cmp_greater: got %b/%h expected 00/00000002", f, r);
        end
    endtask

    task automatic test_shift_logic();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'h1, 32'h3C, 32'd2, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'hF0}) begin
            tests_failed++; $display("FAIL shl_basic: got %b/%h expected 00/000000f0", f, r);
        end
        run_op(4'h5, 32'h3C, 32'd1, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'h1E}) begin
            tests_failed++; $display("FAIL shr_basic: got %b/%h expected 00/0000001e", f, r);
        end
        run_op(4'h1, 32'h3C, 32'd40, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd0}) begin
            tests_failed++; $display("FAIL shl_over: got %b/%h expected 00/00000000", f, r);
        end
        run_op(4'h5, 32'h8000_0000, 32'd32, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd0}) begin
            tests_failed++; $display("FAIL shr_width: got %b/%h expected 00/00000000", f, r);
        end
        run_op(4'h0, 32'h0F0F_0000, 32'd0, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'hF0F0_FFFF}) begin
            tests_failed++; $display("FAIL not_basic: got %b/%h expected 00/f0f0ffff", f, r);
        end
        run_op(4'h7, 32'hF0F0, 32'hFF00, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'hF000}) begin
            tests_failed++; $display("FAIL and_basic: got %b/%h expected 00/0000f000", f, r);
        end
        run_op(4'h8, 32'hF0F0, 32'hFF00, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'hFFF0}) begin
            tests_failed++; $display("FAIL or_basic: got %b/%h expected 00/0000fff0", f, r);
        end
    endtask

    task automatic test_invalid();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'hF, 32'd1, 32'd1, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b10, 32'd0}) begin
            tests_failed++; $display("FAIL invalid_f: got %b/%h expected 10/00000000", f, r);
        end
        run_op(4'hB, 32'd9, 32'd9, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b10, 32'd0}) begin
            tests_failed++; $display("FAIL invalid_b: got %b/%h expected 10/00000000", f, r);
        end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'h2, 32'd15, 32'd5, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd75}) begin
            tests_failed++; $display("FAIL mul_basic: got %b/%h expected 00/0000004b", f, r);
        end
        tests_run++;
        if (l !== 33) begin
            tests_failed++; $display("FAIL mul_latency: got %0d expected 33", l);
        end
        run_op(4'h2, 32'h1_0000, 32'h1_0000, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b11, 32'd0}) begin
            tests_failed++; $display("FAIL mul_overflow: got %b/%h expected 11/00000000", f, r);
        end
        run_op(4'h2, 32'hFFFF, 32'hFFFF, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'hFFFE_0001}) begin
            tests_failed++; $display("FAIL mul_wide: got %b/%h expected 00/fffe0001", f, r);
        end
        run_op(4'h6, 32'd40, 32'd4, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd10}) begin
            tests_failed++; $display("FAIL div_basic: got %b/%h expected 00/0000000a", f, r);
        end
        run_op(4'hA, 32'd43, 32'd5, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd3}) begin
            tests_failed++; $display("FAIL mod_basic: got %b/%h expected 00/00000003", f, r);
        end
        run_op(4'h6, 32'd10, 32'd0, r, f, l);
        tests_run++;
        if ({f, r, l} !== {2'b01, 32'd0, 32'd1}) begin
            tests_failed++; $display("FAIL div_zero: got %b/%h lat %0d expected 01/00000000 lat 1", f, r, l);
        end
    endtask
`else
    task automatic test_muldiv();
        logic [31:0] r; logic [1:0] f; int l;
        run_op(4'h2, 32'd15, 32'd5, r, f, l);
        tests_run++;
        if ({f, r, l} !== {2'b10, 32'd0, 32'd1}) begin
            tests_failed++; $display("FAIL mul_disabled: got %b/%h lat %0d expected 10/00000000 lat 1", f, r, l);
        end
        run_op(4'h6, 32'd40, 32'd4, r, f, l);
        tests_run++;
        if ({f, r, l} !== {2'b10, 32'd0, 32'd1}) begin
            tests_failed++; $display("FAIL div_disabled: got %b/%h lat %0d expected 10/00000000 lat 1", f, r, l);
        end
        run_op(4'hA, 32'd43, 32'd5, r, f, l);
        tests_run++;
        if ({f, r, l} !== {2'b10, 32'd0, 32'd1}) begin
            tests_failed++; $display("FAIL mod_disabled: got %b/%h lat %0d expected 10/00000000 lat 1", f, r, l);
        end
    endtask
`endif

    task automatic test_backpressure();
        int w;
        operation = 4'h3; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clock); #1; w++;
        end
        // A competing request while DONE must be ignored
        in_valid = 1'b1; operation = 4'h4; operand_a = 32'd100; operand_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({out_valid, in_ready, error_flag, result} !== {1'b1, 1'b0, 2'b00, 32'd3}) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b flg=%b res=%h expected 1 0 00 3",
                         i, out_valid, in_ready, error_flag, result);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++; $display("FAIL backpressure_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [1:0] f; int l;
        int w;
        // Reset while a result is waiting in DONE
        operation = 4'h3; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clock); #1; w++;
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy, error_flag, result} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_in_done: got rdy=%b vld=%b busy=%b flg=%b res=%h expected 1 0 0 00 0",
                     in_ready, out_valid, busy, error_flag, result);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
`ifdef ALU_MULDIV_EN
        // Reset while iterating
        operation = 4'h6; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL busy_in_calc: got %b expected 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy, error_flag, result} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_in_calc: got rdy=%b vld=%b busy=%b flg=%b res=%h expected 1 0 0 00 0",
                     in_ready, out_valid, busy, error_flag, result);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_op(4'h6, 32'd9, 32'd3, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd3}) begin
            tests_failed++; $display("FAIL div_after_reset: got %b/%h expected 00/00000003", f, r);
        end
`else
        run_op(4'h3, 32'd9, 32'd3, r, f, l);
        tests_run++;
        if ({f, r} !== {2'b00, 32'd12}) begin
            tests_failed++; $display("FAIL add_after_reset: got %b/%h expected 00/0000000c", f, r);
        end
`endif
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_add();
        test_sub_cmp();
        test_shift_logic();
        test_invalid();
        test_muldiv();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
